// File: rtl/hazard_pkg.sv
// Shared encodings for the hazard/forwarding controller: operand-forward selects and freeze FSM states.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_sel_t;

    typedef enum logic [1:0] {
        ST_RUN  = 2'b00,
        ST_WAIT = 2'b01,
        ST_ERR  = 2'b10
    } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/hazard_fwd_unit.sv
// Hazard/forwarding controller for the 5-stage pipeline plus memory-wait freeze FSM.
//   state   | meaning
//   ST_RUN  | normal flow; freeze only while a new request is outstanding
//   ST_WAIT | waiting for mem_ready, counting cycles toward the timeout
//   ST_ERR  | memory timed out; pipeline frozen until reset
module hazard_fwd_unit
    import hazard_pkg::*;
#(
    parameter int REG_AW  = 4,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fwd_en,
    input  logic [REG_AW-1:0] src1,
    input  logic [REG_AW-1:0] src2,
    input  logic              two_src,
    input  logic [REG_AW-1:0] exe_dest,
    input  logic              exe_wb_en,
    input  logic              exe_mem_r_en,
    input  logic [REG_AW-1:0] mem_dest,
    input  logic              mem_wb_en,
    input  logic [REG_AW-1:0] wb_dest,
    input  logic              wb_wb_en,
    input  logic              branch_taken,
    input  logic              mem_req,
    input  logic              mem_ready,
    input  logic              clr_cnt,
    output logic              hazard_detected,
    output logic              freeze,
    output logic [1:0]        sel_src1,
    output logic [1:0]        sel_src2,
    output logic              mem_timeout,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  freeze_cnt
);

    localparam int WCW = $clog2(TIMEOUT + 1);
    localparam logic [WCW-1:0] TO_VAL = WCW'(TIMEOUT);

    logic exe_hit, mem_hit, hazard;

    assign exe_hit = (src1 == exe_dest) || (two_src && (src2 == exe_dest));
    assign mem_hit = (src1 == mem_dest) || (two_src && (src2 == mem_dest));

    // With forwarding only a load in EXE cannot be bypassed; the flush always wins.
    always_comb begin
        hazard = 1'b0;
        if (fwd_en) hazard = exe_wb_en && exe_mem_r_en && exe_hit;
        else        hazard = (exe_wb_en && exe_hit) || (mem_wb_en && mem_hit);
        if (branch_taken) hazard = 1'b0;
    end

    assign hazard_detected = hazard;

    logic [REG_AW-1:0] r_src1_q, r_src1_d, r_src2_q, r_src2_d;
    logic              r_two_src_q, r_two_src_d, r_valid_q, r_valid_d;
    state_t            state_q, state_d;
    logic [WCW-1:0]    wait_cnt_q, wait_cnt_d;
    logic              mem_timeout_q, mem_timeout_d;
    logic              frz;

    always_comb begin
        r_src1_d    = r_src1_q;
        r_src2_d    = r_src2_q;
        r_two_src_d = r_two_src_q;
        r_valid_d   = r_valid_q;
        if (!frz) begin
            if (branch_taken || hazard) begin
                r_valid_d = 1'b0;
            end else begin
                r_src1_d    = src1;
                r_src2_d    = src2;
                r_two_src_d = two_src;
                r_valid_d   = 1'b1;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        mem_timeout_d = mem_timeout_q;
        frz           = 1'b0;
        case (state_q)
            ST_RUN: begin
                frz = mem_req && !mem_ready;
                if (mem_req && !mem_ready) begin
                    state_d    = ST_WAIT;
                    wait_cnt_d = WCW'(1);
                end
            end
            ST_WAIT: begin
                frz = !mem_ready;
                if (mem_ready) begin
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == TO_VAL) begin
                    state_d       = ST_ERR;
                    mem_timeout_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            ST_ERR: begin
                frz           = 1'b1;
                mem_timeout_d = 1'b1;
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_src1_q      <= '0;
            r_src2_q      <= '0;
            r_two_src_q   <= 1'b0;
            r_valid_q     <= 1'b0;
            state_q       <= ST_RUN;
            wait_cnt_q    <= '0;
            mem_timeout_q <= 1'b0;
        end else begin
            r_src1_q      <= r_src1_d;
            r_src2_q      <= r_src2_d;
            r_two_src_q   <= r_two_src_d;
            r_valid_q     <= r_valid_d;
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    fwd_sel_t sel1, sel2;

    // MEM result is younger than WB, so it takes priority.
    always_comb begin
        sel1 = FWD_REG;
        sel2 = FWD_REG;
        if (fwd_en && r_valid_q) begin
            if (mem_wb_en && (r_src1_q == mem_dest))     sel1 = FWD_MEM;
            else if (wb_wb_en && (r_src1_q == wb_dest))  sel1 = FWD_WB;
            if (r_two_src_q) begin
                if (mem_wb_en && (r_src2_q == mem_dest))    sel2 = FWD_MEM;
                else if (wb_wb_en && (r_src2_q == wb_dest)) sel2 = FWD_WB;
            end
        end
    end

    assign sel_src1    = sel1;
    assign sel_src2    = sel2;
    assign freeze      = frz;
    assign mem_timeout = mem_timeout_q;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clr_cnt),
        .inc (hazard && !frz),
        .cnt (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_freeze_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clr_cnt),
        .inc (frz),
        .cnt (freeze_cnt)
    );

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Directed bench for hazard_fwd_unit; a second narrow-counter instance exercises saturation.
module tb_hazard_fwd_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       fwd_en, two_src, exe_wb_en, exe_mem_r_en, mem_wb_en, wb_wb_en;
    logic       branch_taken, mem_req, mem_ready, clr_cnt;
    logic [3:0] src1, src2, exe_dest, mem_dest, wb_dest;

    logic        hz_a, frz_a, to_a;
    logic [1:0]  s1_a, s2_a;
    logic [15:0] sc_a, fc_a;
    logic        hz_b, frz_b, to_b;
    logic [1:0]  s1_b, s2_b;
    logic [3:0]  sc_b, fc_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    hazard_fwd_unit #(.REG_AW(4), .CNT_W(16), .TIMEOUT(4)) u_dut (
        .clk(clk), .rst(rst), .fwd_en(fwd_en), .src1(src1), .src2(src2), .two_src(two_src),
        .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
        .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .wb_dest(wb_dest), .wb_wb_en(wb_wb_en),
        .branch_taken(branch_taken), .mem_req(mem_req), .mem_ready(mem_ready), .clr_cnt(clr_cnt),
        .hazard_detected(hz_a), .freeze(frz_a), .sel_src1(s1_a), .sel_src2(s2_a),
        .mem_timeout(to_a), .stall_cnt(sc_a), .freeze_cnt(fc_a)
    );

    hazard_fwd_unit #(.REG_AW(4), .CNT_W(4), .TIMEOUT(4)) u_dut_sat (
        .clk(clk), .rst(rst), .fwd_en(fwd_en), .src1(src1), .src2(src2), .two_src(two_src),
        .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
        .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .wb_dest(wb_dest), .wb_wb_en(wb_wb_en),
        .branch_taken(branch_taken), .mem_req(mem_req), .mem_ready(mem_ready), .clr_cnt(clr_cnt),
        .hazard_detected(hz_b), .freeze(frz_b), .sel_src1(s1_b), .sel_src2(s2_b),
        .mem_timeout(to_b), .stall_cnt(sc_b), .freeze_cnt(fc_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        fwd_en = 0; src1 = 0; src2 = 0; two_src = 0;
        exe_dest = 0; exe_wb_en = 0; exe_mem_r_en = 0;
        mem_dest = 0; mem_wb_en = 0; wb_dest = 0; wb_wb_en = 0;
        branch_taken = 0; mem_req = 0; mem_ready = 0; clr_cnt = 0;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        repeat (2) cyc();
        check_eq("rst_hazard", hz_a, 0);
        check_eq("rst_freeze", frz_a, 0);
        check_eq("rst_sel1", s1_a, 0);
        check_eq("rst_sel2", s2_a, 0);
        check_eq("rst_timeout", to_a, 0);
        check_eq("rst_stall_cnt", sc_a, 0);
        check_eq("rst_freeze_cnt", fc_a, 0);
        rst = 1'b0;
        cyc();

        // Forwarding off: full RAW stall against EXE
        src1 = 3; exe_dest = 3; exe_wb_en = 1;
        #1 check_eq("nofwd_exe_hazard", hz_a, 1);
        cyc();
        check_eq("nofwd_stall_cnt1", sc_a, 1);
        cyc();
        check_eq("nofwd_stall_cnt2", sc_a, 2);
        src1 = 7; src2 = 5; two_src = 0; mem_dest = 5; mem_wb_en = 1;
        #1 check_eq("nofwd_src2_unused", hz_a, 0);
        two_src = 1;
        #1 check_eq("nofwd_mem_src2_hazard", hz_a, 1);
        idle();
        cyc();
        check_eq("nofwd_stall_hold", sc_a, 2);

        // Forwarding on: ALU result in EXE needs no stall, then forwards from MEM
        fwd_en = 1; src1 = 3; exe_dest = 3; exe_wb_en = 1;
        #1 check_eq("fwd_alu_no_stall", hz_a, 0);
        cyc();
        exe_wb_en = 0; src1 = 0; mem_dest = 3; mem_wb_en = 1; wb_dest = 3; wb_wb_en = 1;
        #1 check_eq("fwd_sel1_mem", s1_a, 2'b01);
        check_eq("fwd_sel2_unused", s2_a, 2'b00);

        // Load-use: one stall, bubble, then WB and MEM forwarding on src2
        idle(); fwd_en = 1;
        src1 = 9; src2 = 4; two_src = 1; exe_dest = 4; exe_wb_en = 1; exe_mem_r_en = 1;
        #1 check_eq("ldu_hazard", hz_a, 1);
        cyc();
        exe_wb_en = 0; exe_mem_r_en = 0; mem_dest = 4; mem_wb_en = 1;
        #1 check_eq("ldu_released", hz_a, 0);
        check_eq("ldu_bubble_sel2", s2_a, 2'b00);
        check_eq("ldu_stall_cnt", sc_a, 3);
        cyc();
        mem_wb_en = 0; wb_dest = 4; wb_wb_en = 1;
        #1 check_eq("ldu_sel2_wb", s2_a, 2'b10);
        check_eq("ldu_sel1_none", s1_a, 2'b00);
        mem_dest = 4; mem_wb_en = 1;
        #1 check_eq("ldu_sel2_mem_prio", s2_a, 2'b01);

        // Memory wait: 3 frozen cycles, r_* held, hazard not counted
        idle(); fwd_en = 1; src1 = 2; src2 = 6; two_src = 1; clr_cnt = 1;
        cyc();
        clr_cnt = 0; mem_dest = 2; mem_wb_en = 1; wb_dest = 6; wb_wb_en = 1;
        src1 = 3; src2 = 8; exe_dest = 3; exe_wb_en = 1; exe_mem_r_en = 1;
        mem_req = 1; mem_ready = 0;
        #1 check_eq("frz_first_cycle", frz_a, 1);
        check_eq("frz_hazard_visible", hz_a, 1);
        for (int i = 1; i < 3; i++) begin
            cyc();
            check_eq($sformatf("frz_wait%0d", i), frz_a, 1);
            check_eq($sformatf("frz_hold_sel1_%0d", i), s1_a, 2'b01);
            check_eq($sformatf("frz_hold_sel2_%0d", i), s2_a, 2'b10);
        end
        cyc();
        mem_ready = 1; exe_wb_en = 0; exe_mem_r_en = 0;
        #1 check_eq("frz_release", frz_a, 0);
        cyc();
        mem_req = 0; mem_ready = 0;
        check_eq("frz_cnt3", fc_a, 3);
        check_eq("frz_no_stall_count", sc_a, 0);
        #1 check_eq("frz_back_run", frz_a, 0);

        // Flush beats load-use; the bubble must not forward
        idle(); fwd_en = 1; src1 = 5;
        cyc();
        exe_dest = 5; exe_wb_en = 1; exe_mem_r_en = 1; branch_taken = 1;
        #1 check_eq("flush_hazard", hz_a, 0);
        cyc();
        branch_taken = 0; exe_wb_en = 0; exe_mem_r_en = 0; mem_dest = 5; mem_wb_en = 1;
        #1 check_eq("flush_sel1", s1_a, 2'b00);

        // Saturation on the 4-bit counter instance, then clear priority
        idle(); src1 = 1; exe_dest = 1; exe_wb_en = 1; clr_cnt = 1;
        cyc();
        clr_cnt = 0;
        repeat (20) cyc();
        check_eq("sat_narrow_stall", sc_b, 4'hF);
        check_eq("sat_wide_stall", sc_a, 20);
        clr_cnt = 1;
        cyc();
        clr_cnt = 0;
        check_eq("clr_wide_stall", sc_a, 0);
        check_eq("clr_narrow_stall", sc_b, 0);

        // Timeout with TIMEOUT=4: error after the fifth wait edge, sticky until reset
        idle(); mem_req = 1; mem_ready = 0;
        repeat (4) cyc();
        check_eq("to_not_yet", to_a, 0);
        check_eq("to_frozen", frz_a, 1);
        cyc();
        check_eq("to_asserted", to_a, 1);
        mem_req = 0; mem_ready = 1;
        repeat (2) cyc();
        check_eq("to_sticky", to_a, 1);
        check_eq("to_err_frozen", frz_a, 1);
        #2 rst = 1'b1;
        #1 check_eq("rst_err_timeout", to_a, 0);
        check_eq("rst_err_freeze", frz_a, 0);
        check_eq("rst_err_freeze_cnt", fc_a, 0);
        check_eq("rst_err_stall_cnt", sc_a, 0);
        check_eq("rst_err_sel1", s1_a, 0);
        cyc();
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
